// File: rtl/im_loader_if.sv
// Byte-stream loader bus: host-side stream handshake, IM write port and status.
// The loader drives the slave side; the host/debug link (or a bench) drives master.
interface im_loader_if;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        im_we;
  logic [10:0] im_idx;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, im_we, im_idx, im_addr, im_wdata, cpu_hold, busy, done, error
  );

  modport master (
    output start, in_data, in_valid,
    input  in_ready, im_we, im_idx, im_addr, im_wdata, cpu_hold, busy, done, error
  );
endinterface

// File: rtl/im_loader.sv
// Instruction-memory loader. Receives a framed program image as a byte stream
// (16-bit big-endian word count, big-endian data words, XOR checksum byte),
// packs it into 32-bit words and writes them into IM. Holds the CPU in reset
// until a load finishes with a matching checksum.
module im_loader #(
  parameter int unsigned DEPTH = 2048,
  parameter logic [31:0] BASE  = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  im_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,   // one-cycle IM write after the 4th byte of a word
    S_CSUM
  } state_t;

  state_t      r_state, w_next;
  logic [15:0] r_len;
  logic [11:0] r_k;       // 12 bits so a full fill (k == DEPTH) cannot alias to 0
  logic [31:0] r_pack;
  logic [1:0]  r_bcnt;
  logic [7:0]  r_csum;
  logic        r_busy, r_done, r_error, r_hold;

  logic        w_ready;
  logic        w_fire;
  logic [15:0] w_len;
  logic        w_too_long;
  logic        w_last_word;
  logic        w_csum_ok;
  logic [31:0] w_addr;

  assign w_fire      = bus.in_valid & w_ready;
  assign w_len       = {r_len[15:8], bus.in_data};
  assign w_too_long  = (w_len > 16'(DEPTH));
  assign w_last_word = ({4'd0, r_k} == (r_len - 16'd1));
  assign w_csum_ok   = (bus.in_data == r_csum);
  assign w_addr      = BASE + {18'd0, r_k, 2'b00};

  // State register; reset returns to IDLE at once, which also drops im_we.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and stream-ready decode; a cycle without in_valid holds state.
  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        w_ready = 1'b1;
        if (bus.in_valid) w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        w_ready = 1'b1;
        if (bus.in_valid) begin
          if (w_too_long)         w_next = S_IDLE;
          else if (w_len == 16'd0) w_next = S_CSUM;
          else                    w_next = S_DATA;
        end
      end
      S_DATA: begin
        w_ready = 1'b1;
        if (bus.in_valid && r_bcnt == 2'd3) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_next = w_last_word ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        w_ready = 1'b1;
        if (bus.in_valid) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: length capture, byte packing, word counter, checksum and status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len   <= '0;
      r_k     <= '0;
      r_pack  <= '0;
      r_bcnt  <= '0;
      r_csum  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_hold  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_csum  <= '0;
            r_busy  <= 1'b1;
            r_hold  <= 1'b1;
          end
        end
        S_LEN_HI: begin
          if (w_fire) begin
            r_len[15:8] <= bus.in_data;
            r_csum      <= r_csum ^ bus.in_data;
          end
        end
        S_LEN_LO: begin
          if (w_fire) begin
            r_len  <= w_len;
            r_csum <= r_csum ^ bus.in_data;
            r_k    <= '0;
            r_bcnt <= '0;
            if (w_too_long) begin
              r_error <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (w_fire) begin
            r_pack <= {r_pack[23:0], bus.in_data};
            r_bcnt <= r_bcnt + 2'd1;
            r_csum <= r_csum ^ bus.in_data;
          end
        end
        S_WRITE: begin
          r_k <= r_k + 12'd1;
        end
        S_CSUM: begin
          if (w_fire) begin
            r_done  <= w_csum_ok;
            r_error <= ~w_csum_ok;
            r_hold  <= ~w_csum_ok;
            r_busy  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready = w_ready;
  assign bus.im_we    = (r_state == S_WRITE);
  assign bus.im_addr  = w_addr;
  assign bus.im_idx   = {~w_addr[12], w_addr[11:2]};
  assign bus.im_wdata = r_pack;
  assign bus.cpu_hold = r_hold;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.error    = r_error;

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: directed frames, an expected-write queue built from the
// frame contents, and a compare process that checks every IM write.
module tb_im_loader;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  im_loader_if ifc ();

  im_loader #(.DEPTH(2048), .BASE(32'h0000_3000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  typedef struct {
    logic [10:0] idx;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] fw[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          write_cnt = 0;
  logic [10:0] last_idx  = '0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Every IM write must match the next expected word from the model.
  always @(negedge clk) begin
    if (!reset && ifc.im_we === 1'b1) begin
      write_cnt++;
      last_idx  = ifc.im_idx;
      last_addr = ifc.im_addr;
      last_data = ifc.im_wdata;
      check("ready_in_write", {31'd0, ifc.in_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: idx %h addr %h data %h with none pending",
                 ifc.im_idx, ifc.im_addr, ifc.im_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_idx",  {21'd0, ifc.im_idx}, {21'd0, e.idx});
        check("wr_addr", ifc.im_addr,  e.addr);
        check("wr_data", ifc.im_wdata, e.data);
      end
    end
  end

  // Drive one byte, optionally after a bubble of idle cycles; returns #1 after the handshake edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      ifc.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    ifc.in_data  = b;
    ifc.in_valid = 1'b1;
    t = 0;
    while (ifc.in_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL handshake_timeout: byte %h never accepted", b);
      ifc.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    check("start_busy", {31'd0, ifc.busy},     32'd1);
    check("start_hold", {31'd0, ifc.cpu_hold}, 32'd1);
    check("start_done", {31'd0, ifc.done},     32'd0);
    check("start_err",  {31'd0, ifc.error},    32'd0);
  endtask

  // Build a frame of 'len' words from fw[], predict writes and outcome, stream it.
  task automatic run_frame(input int len, input bit bad_cs, input int bubble_at, input bit start_mid);
    logic [7:0]  bytes[$];
    logic [7:0]  cs;
    logic [31:0] w;
    logic [15:0] l16;
    bit          reject;
    bit          good;
    int          nw;
    l16    = 16'(len);
    reject = (len > 2048);
    bytes.push_back(l16[15:8]);
    bytes.push_back(l16[7:0]);
    if (!reject) begin
      for (int k = 0; k < len; k++) begin
        w = fw[k];
        bytes.push_back(w[31:24]);
        bytes.push_back(w[23:16]);
        bytes.push_back(w[15:8]);
        bytes.push_back(w[7:0]);
        exp_q.push_back('{11'(k), 32'h0000_3000 + 32'(4 * k), w});
      end
      cs = 8'h00;
      foreach (bytes[i]) cs = cs ^ bytes[i];
      if (bad_cs) cs = cs ^ 8'h01;
      bytes.push_back(cs);
    end
    write_cnt = 0;
    pulse_start();
    foreach (bytes[i]) begin
      if (start_mid && i == 1) ifc.start = 1'b1;
      send_byte(bytes[i], (i == bubble_at) ? 3 : 0);
      ifc.start = 1'b0;
    end
    nw   = reject ? 0 : len;
    good = !reject && !bad_cs;
    check("write_count",  write_cnt, nw);
    check("pending",      exp_q.size(), 32'd0);
    check("end_busy",     {31'd0, ifc.busy},     32'd0);
    check("end_ready",    {31'd0, ifc.in_ready}, 32'd0);
    check("end_done",     {31'd0, ifc.done},     {31'd0, good});
    check("end_error",    {31'd0, ifc.error},    {31'd0, !good});
    check("end_hold",     {31'd0, ifc.cpu_hold}, {31'd0, !good});
  endtask

  task automatic load_test1_words();
    fw.delete();
    fw.push_back(32'h1234_5678);
    fw.push_back(32'h9ABC_DEF0);
  endtask

  initial begin
    ifc.start    = 1'b0;
    ifc.in_data  = 8'h00;
    ifc.in_valid = 1'b0;
    reset        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ifc.in_ready}, 32'd0);
    check("rst_we",    {31'd0, ifc.im_we},    32'd0);
    check("rst_hold",  {31'd0, ifc.cpu_hold}, 32'd1);
    check("rst_busy",  {31'd0, ifc.busy},     32'd0);
    check("rst_done",  {31'd0, ifc.done},     32'd0);
    check("rst_error", {31'd0, ifc.error},    32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // in_valid in IDLE is ignored
    ifc.in_valid = 1'b1;
    ifc.in_data  = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    check("idle_valid_busy", {31'd0, ifc.busy}, 32'd0);

    // 1: good two-word image
    load_test1_words();
    run_frame(2, 1'b0, -1, 1'b0);
    check("t1_last_idx",  {21'd0, last_idx}, 32'd1);
    check("t1_last_addr", last_addr, 32'h0000_3004);
    check("t1_last_data", last_data, 32'h9ABC_DEF0);

    // 2: same image, checksum 0x03
    load_test1_words();
    run_frame(2, 1'b1, -1, 1'b0);
    check("t2_last_data", last_data, 32'h9ABC_DEF0);

    // 3: oversize length is rejected after LEN_LO
    run_frame(2049, 1'b0, -1, 1'b0);

    // 4: empty image
    fw.delete();
    run_frame(0, 1'b0, -1, 1'b0);

    // 4b: test 1 with a 3-cycle bubble in the middle of the first word
    load_test1_words();
    run_frame(2, 1'b0, 3, 1'b0);
    check("t4b_last_addr", last_addr, 32'h0000_3004);

    // 5: reset during DATA after 5 bytes
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h56, 0);
    reset = 1'b1;
    #1;
    check("midrst_we",    {31'd0, ifc.im_we},    32'd0);
    check("midrst_hold",  {31'd0, ifc.cpu_hold}, 32'd1);
    check("midrst_busy",  {31'd0, ifc.busy},     32'd0);
    check("midrst_ready", {31'd0, ifc.in_ready}, 32'd0);
    check("midrst_done",  {31'd0, ifc.done},     32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    // fresh load with a start pulse while busy
    load_test1_words();
    run_frame(2, 1'b0, -1, 1'b1);

    // 6: full fill
    fw.delete();
    for (int k = 0; k < 2048; k++) fw.push_back(32'(k) * 32'h9E37_79B1 + 32'h0102_0304);
    run_frame(2048, 1'b0, -1, 1'b0);
    check("t6_last_idx",  {21'd0, last_idx}, 32'h0000_07FF);
    check("t6_last_addr", last_addr, 32'h0000_4FFC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
